// File: rtl/dlfp_cmp_reduce_if.sv
// Stream interface for the DLFloat compare/reduce block.
//
// Handshake: a beat on either channel transfers on a rising clk edge where
// valid and ready are both 1. A producer holding valid keeps its payload
// stable until the transfer; ready may depend on the consumer's state but
// never on the producer's valid.
interface dlfp_cmp_reduce_if #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int IDX_W = 8
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic [2:0]       sel;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     c_out;
    logic [IDX_W-1:0] out_idx;
    logic [4:0]       exceptions;

    modport master (
        output in_valid, a1, b1, sel, in_last, out_ready,
        input  in_ready, out_valid, c_out, out_idx, exceptions
    );

    modport slave (
        input  in_valid, a1, b1, sel, in_last, out_ready,
        output in_ready, out_valid, c_out, out_idx, exceptions
    );
endinterface

// File: rtl/dlfp_cmp_reduce.sv
// DLFloat comparator: elementwise min/max/eq/lt/le and streaming vector
// min/max reduction with winner index. Results are held in HOLD until the
// consumer takes them; a new input beat can be accepted in that same cycle.
module dlfp_cmp_reduce #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dlfp_cmp_reduce_if.slave     bus,
    output logic [1:0]           o_dbg_state
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0]     C_NAN     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     C_ONES    = '1;
    localparam logic [IDX_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // NaN is the single encoding with exponent and mantissa both all-ones.
    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[W-2:MAN_W]) && (&x[MAN_W-1:0]);
    endfunction

    // Ordered compare, returns {lt, gt}; +0 and -0 are equal.
    function automatic logic [1:0] cmp_ord(input logic [W-1:0] x, input logic [W-1:0] y);
        logic lt;
        logic gt;
        lt = 1'b0;
        gt = 1'b0;
        if ((~|x[W-2:0]) && (~|y[W-2:0])) begin
            lt = 1'b0;
            gt = 1'b0;
        end else if (x[W-1] != y[W-1]) begin
            lt = x[W-1];
            gt = y[W-1];
        end else if (!x[W-1]) begin
            lt = x[W-2:0] < y[W-2:0];
            gt = x[W-2:0] > y[W-2:0];
        end else begin
            lt = x[W-2:0] > y[W-2:0];
            gt = x[W-2:0] < y[W-2:0];
        end
        return {lt, gt};
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_acc;
    logic [IDX_W-1:0] r_acc_idx;
    logic [IDX_W-1:0] r_cnt;
    logic             r_acc_nan;
    logic             r_inv;
    logic             r_ovf;
    logic             r_sel_max;
    logic [W-1:0]     r_c_out;
    logic [IDX_W-1:0] r_out_idx;
    logic [4:0]       r_exc;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_start;
    logic             w_start_red;
    logic             w_red_beat;
    logic             w_load_ew;
    logic             w_load_red;
    logic             w_a_nan;
    logic             w_b_nan;
    logic             w_ab_unord;
    logic [1:0]       w_ab_cmp;
    logic             w_ab_lt;
    logic             w_ab_gt;
    logic             w_ab_eq;
    logic [1:0]       w_ea_cmp;
    logic [W-1:0]     w_ew_res;
    logic             w_ew_inv;
    logic             w_better;
    logic [W-1:0]     w_acc_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_cnt_nxt;
    logic             w_acc_nan_nxt;
    logic             w_inv_nxt;
    logic             w_ovf_nxt;
    logic [W-1:0]     w_red_res;

    assign w_in_ready  = (r_state != S_HOLD) || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_start     = w_accept && (r_state != S_ACCUM);
    assign w_start_red = w_start && (bus.sel[2:1] == 2'b11);
    assign w_red_beat  = w_start_red || (w_accept && (r_state == S_ACCUM));
    assign w_load_ew   = w_start && !w_start_red;
    assign w_load_red  = w_red_beat && bus.in_last;

    assign w_a_nan    = is_nan(bus.a1);
    assign w_b_nan    = is_nan(bus.b1);
    assign w_ab_unord = w_a_nan || w_b_nan;
    assign w_ab_cmp   = cmp_ord(bus.a1, bus.b1);
    assign w_ab_lt    = !w_ab_unord && w_ab_cmp[1];
    assign w_ab_gt    = !w_ab_unord && w_ab_cmp[0];
    assign w_ab_eq    = !w_ab_unord && !w_ab_cmp[1] && !w_ab_cmp[0];
    assign w_ea_cmp   = cmp_ord(bus.a1, r_acc);

    // Elementwise result and invalid flag.
    always_comb begin
        w_ew_res = '0;
        w_ew_inv = 1'b0;
        case (bus.sel)
            3'b001: begin
                if (w_a_nan && w_b_nan) w_ew_res = C_NAN;
                else if (w_a_nan)       w_ew_res = bus.b1;
                else if (w_b_nan)       w_ew_res = bus.a1;
                else                    w_ew_res = w_ab_lt ? bus.a1 : bus.b1;
                w_ew_inv = w_ab_unord;
            end
            3'b010: begin
                if (w_a_nan && w_b_nan) w_ew_res = C_NAN;
                else if (w_a_nan)       w_ew_res = bus.b1;
                else if (w_b_nan)       w_ew_res = bus.a1;
                else                    w_ew_res = w_ab_gt ? bus.a1 : bus.b1;
                w_ew_inv = w_ab_unord;
            end
            3'b011: begin
                w_ew_res = w_ab_eq ? C_ONES : '0;
                w_ew_inv = w_ab_unord;
            end
            3'b100: begin
                w_ew_res = w_ab_lt ? C_ONES : '0;
                w_ew_inv = w_ab_unord;
            end
            3'b101: begin
                w_ew_res = (w_ab_lt || w_ab_eq) ? C_ONES : '0;
                w_ew_inv = w_ab_unord;
            end
            default: begin
                w_ew_res = '0;
                w_ew_inv = 1'b0;
            end
        endcase
    end

    // Next accumulator contents for a reduction beat; only strictly better
    // elements replace, so ties keep the earlier index.
    always_comb begin
        w_better      = 1'b0;
        w_acc_nxt     = r_acc;
        w_idx_nxt     = r_acc_idx;
        w_cnt_nxt     = r_cnt;
        w_acc_nan_nxt = r_acc_nan;
        w_inv_nxt     = r_inv;
        w_ovf_nxt     = r_ovf;
        if (w_start_red) begin
            w_acc_nxt     = bus.a1;
            w_idx_nxt     = '0;
            w_cnt_nxt     = IDX_W'(1);
            w_acc_nan_nxt = w_a_nan;
            w_inv_nxt     = w_a_nan;
            w_ovf_nxt     = 1'b0;
        end else begin
            w_better = !w_a_nan &&
                       (r_acc_nan || (r_sel_max ? w_ea_cmp[0] : w_ea_cmp[1]));
            if (w_better) begin
                w_acc_nxt     = bus.a1;
                w_idx_nxt     = r_cnt;
                w_acc_nan_nxt = 1'b0;
            end
            w_inv_nxt = r_inv || w_a_nan;
            if (r_cnt == C_CNT_MAX) w_ovf_nxt = 1'b1;
            else                    w_cnt_nxt = r_cnt + IDX_W'(1);
        end
        w_red_res = w_acc_nan_nxt ? C_NAN : w_acc_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HOLD: begin
                if (r_state == S_HOLD && !bus.out_ready) w_state_nxt = S_HOLD;
                else if (w_start_red)                    w_state_nxt = bus.in_last ? S_HOLD : S_ACCUM;
                else if (w_start)                        w_state_nxt = S_HOLD;
                else                                     w_state_nxt = S_IDLE;
            end
            S_ACCUM: begin
                if (w_accept && bus.in_last) w_state_nxt = S_HOLD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Reduction accumulator, counter, sticky flags and latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_acc_idx <= '0;
            r_cnt     <= '0;
            r_acc_nan <= 1'b0;
            r_inv     <= 1'b0;
            r_ovf     <= 1'b0;
            r_sel_max <= 1'b0;
        end else if (w_red_beat) begin
            r_acc     <= w_acc_nxt;
            r_acc_idx <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc_nan <= w_acc_nan_nxt;
            r_inv     <= w_inv_nxt;
            r_ovf     <= w_ovf_nxt;
            if (w_start_red) r_sel_max <= bus.sel[0];
        end
    end

    // Result registers, loaded only when a result is produced so HOLD keeps them stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_out   <= '0;
            r_out_idx <= '0;
            r_exc     <= '0;
        end else if (w_load_red) begin
            r_c_out   <= w_red_res;
            r_out_idx <= w_idx_nxt;
            r_exc     <= {w_inv_nxt, 1'b0, w_ovf_nxt, 1'b0, (w_red_res == '0)};
        end else if (w_load_ew) begin
            r_c_out   <= w_ew_res;
            r_out_idx <= '0;
            r_exc     <= {w_ew_inv, 1'b0, 1'b0, 1'b0, (w_ew_res == '0)};
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == S_HOLD);
    assign bus.c_out      = r_c_out;
    assign bus.out_idx    = r_out_idx;
    assign bus.exceptions = r_exc;
    assign o_dbg_state    = r_state;
endmodule
